// File: rtl/v_ram_stream_pkg.sv
// Shared types and sizing for the RAM stream reader and its skid FIFO.
package v_ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        ZERO  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 3;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    // Circular pointer advance for a non-power-of-two depth.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/v_ram_stream_fifo.sv
// Small synchronous FIFO with head-of-queue output; absorbs the RAM read latency.
// Pop on empty is ignored; the caller's issue rule keeps push from overflowing.
module v_ram_stream_fifo
    import v_ram_stream_pkg::*;
#(
    parameter int W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/v_ram_stream_reader.sv
// Streams `length` words from a 1-cycle-latency RAM starting at base_addr (wrapping).
// Reads are throttled by FIFO occupancy plus the in-flight read, so m_ready never reaches ram_addr.
module v_ram_stream_reader
    import v_ram_stream_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    localparam int SUM_W = CNT_W + 1;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    addr_q;
    logic [AW:0]      rem_q;
    logic             inflight_q;
    logic             last_inflight_q;
    logic             done_q;
    logic             issue;
    logic             pop;
    logic             last_accepted;
    logic             finish;
    logic             accept;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [DW:0]      head;

    // The in-flight read already owns a FIFO slot it will land in next cycle.
    assign issue = (state == RUN) &&
                   ((SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH));
    assign accept        = (state == IDLE) && start && (length != '0);
    assign pop           = m_valid && m_ready;
    assign last_accepted = pop && head[DW];

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = (length == '0) ? ZERO : RUN;
            RUN:   if (issue && rem_q == (AW+1)'(1)) state_nxt = DRAIN;
            DRAIN: if (last_accepted) begin
                       state_nxt = IDLE;
                       finish    = 1'b1;
                   end
            ZERO:  begin
                       state_nxt = IDLE;
                       finish    = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state           <= state_nxt;
            done_q          <= finish;
            inflight_q      <= issue;
            last_inflight_q <= issue && (rem_q == (AW+1)'(1));
            if (accept) begin
                addr_q <= base_addr;
                rem_q  <= length;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
        end
    end

    v_ram_stream_fifo #(.W(DW + 1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({last_inflight_q, ram_dout}),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign ram_addr = addr_q;
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign m_valid  = !fifo_empty;
    assign m_data   = head[DW-1:0];
    assign m_last   = head[DW];

endmodule
